uart_tx_frame_ctrl: RTL



---
 rtl/uart_tx_frame_ctrl_if.sv | 30 +++
 rtl/uart_tx_frame_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_frame_ctrl_if                                                |
// | Data-source / serial-line bundle for the UART TX frame engine.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  data_ack;
  logic                  TX_OUT;
  logic                  busy;
  logic                  frame_done;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    input  data_ack, TX_OUT, busy, frame_done
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    output data_ack, TX_OUT, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_frame_ctrl                                                   |
// | UART TX frame engine: start, LSB-first data, optional parity, 1/2    |
// | stop bits, optional back-to-back frames. Rev 1.0                     |
// +----------------------------------------------------------------------+
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int BACK2BACK  = 1
) (
  input  wire                     CLK,
  input  wire                     RST,
  uart_tx_frame_ctrl_if.slave     bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   par_en_q, par_en_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop2_q, stop2_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   w_last_stop;
  logic                   w_accept;

  assign w_last_stop = (state_q == S_STOP) && (stop_cnt_q == stop2_q);
  // Gated by RST so no accept strobe escapes while the engine is held in reset.
  assign w_accept    = !RST && bus.Data_Valid &&
                       ((state_q == S_IDLE) || ((BACK2BACK != 0) && w_last_stop));

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;

    case (state_q)
      S_IDLE:   if (w_accept) state_d = S_START;
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_cnt_q == C_LAST_BIT) begin
          state_d    = par_en_q ? S_PARITY : S_STOP;
          stop_cnt_d = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        state_d    = S_STOP;
        stop_cnt_d = 1'b0;
      end
      S_STOP: begin
        if (w_last_stop) state_d = w_accept ? S_START : S_IDLE;
        else             stop_cnt_d = 1'b1;
      end
      default:  state_d = S_IDLE;
    endcase

    // Parity is folded into one latched bit so later PAR_TYP changes cannot leak in.
    if (w_accept) begin
      shreg_d   = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_bit_d = (^bus.P_DATA) ^ bus.PAR_TYP;
      stop2_d   = bus.STOP2;
    end

    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA: begin
        tx_d    = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
      S_PARITY: tx_d = par_bit_q;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (stop_cnt_d == stop2_d);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.data_ack   = w_accept;
  assign bus.TX_OUT     = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
`default_nettype wire
